// File: rtl/router_pkg.sv
// Shared types and helpers for the 1-to-N packet router.
package router_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_PARITY  = 2'd2,
    ST_DROP    = 2'd3
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/router_if.sv
// Source-side stream plus per-port reader signals of the router.
interface router_if #(parameter int DATA_W = 8, parameter int NUM_PORTS = 3);
  logic [DATA_W-1:0]           data;
  logic                        packet_valid;
  logic                        suspend_data;
  logic                        err;
  logic                        drop;
  logic [NUM_PORTS-1:0]        read_enb;
  logic [NUM_PORTS-1:0]        vld_out;
  logic [NUM_PORTS*DATA_W-1:0] data_out;
  logic [NUM_PORTS-1:0]        timeout;

  modport master (output data, packet_valid, read_enb,
                  input  suspend_data, err, drop, vld_out, data_out, timeout);
  modport slave  (input  data, packet_valid, read_enb,
                  output suspend_data, err, drop, vld_out, data_out, timeout);
endinterface

// File: rtl/router_fifo.sv
// Per-port FIFO: synchronous write, registered read, flush clears pointers only.
module router_fifo import router_pkg::*; #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              flush,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);
  localparam int AW = clog2(FIFO_DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wptr, rptr;

  // extra wrap bit distinguishes full from empty
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      rd_data <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en && !full) wptr <= wptr + ONE;
      if (rd_en && !empty) begin
        rd_data <= mem[rptr[AW-1:0]];
        rptr    <= rptr + ONE;
      end
    end
  end

  always_ff @(posedge clock)
    if (wr_en && !full && !flush) mem[wptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/router_1xn.sv
// 1-to-N byte-serial packet router: header steering, parity check, per-port stall flush.
module router_1xn import router_pkg::*; #(
  parameter int DATA_W     = 8,
  parameter int NUM_PORTS  = 3,
  parameter int ADDR_W     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input logic     clock,
  input logic     reset,
  router_if.slave bus
);
  localparam int LW = DATA_W - ADDR_W;
  localparam int CW = LW + 1;
  localparam int TW = clog2(TIMEOUT + 1);
  localparam int NA = 1 << ADDR_W;
  localparam logic [CW-1:0] ONE = CW'(1);

  state_e                             state;
  logic [ADDR_W-1:0]                  dest;
  logic [CW-1:0]                      count;
  logic [DATA_W-1:0]                  acc;
  logic                               err_q, drop_q;
  logic [NUM_PORTS-1:0]               full, empty, wr_en, flush, tpulse;
  logic [NUM_PORTS-1:0][DATA_W-1:0]   rd_data;
  logic [NUM_PORTS-1:0][TW-1:0]       tcnt;
  logic [NA-1:0]                      full_x, flush_x;
  logic [ADDR_W-1:0]                  hdr_addr, wr_port;
  logic [LW-1:0]                      hdr_len;
  logic                               addr_ok, suspend, accept, wr_any;

  assign hdr_addr = bus.data[ADDR_W-1:0];
  assign hdr_len  = bus.data[DATA_W-1:ADDR_W];
  assign addr_ok  = int'(hdr_addr) < NUM_PORTS;
  assign full_x   = NA'(full);
  assign flush_x  = NA'(flush);

  always_comb begin
    suspend = 1'b0;
    case (state)
      ST_IDLE:               suspend = bus.packet_valid && addr_ok && full_x[hdr_addr];
      ST_PAYLOAD, ST_PARITY: suspend = full_x[dest];
      default:               suspend = 1'b0;
    endcase
  end

  assign accept  = bus.packet_valid && !suspend;
  assign wr_port = (state == ST_IDLE) ? hdr_addr : dest;
  assign wr_any  = accept && ((state == ST_IDLE && addr_ok) ||
                              state == ST_PAYLOAD || state == ST_PARITY);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign wr_en[p] = wr_any && (int'(wr_port) == p);
    assign flush[p] = !empty[p] && !bus.read_enb[p] && (tcnt[p] == TW'(TIMEOUT - 1));

    router_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (wr_en[p]),
      .rd_en   (bus.read_enb[p]),
      .flush   (flush[p]),
      .wr_data (bus.data),
      .rd_data (rd_data[p]),
      .full    (full[p]),
      .empty   (empty[p])
    );

    // counts consecutive cycles a non-empty port goes unread
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        tcnt[p]   <= '0;
        tpulse[p] <= 1'b0;
      end else begin
        tpulse[p] <= flush[p];
        if (flush[p] || empty[p] || bus.read_enb[p]) tcnt[p] <= '0;
        else                                         tcnt[p] <= tcnt[p] + TW'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      dest   <= '0;
      count  <= '0;
      acc    <= '0;
      err_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      err_q  <= 1'b0;
      drop_q <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          if (!addr_ok) begin
            drop_q <= 1'b1;
            count  <= {1'b0, hdr_len} + ONE;
            state  <= ST_DROP;
          end else if (flush_x[hdr_addr]) begin
            count <= {1'b0, hdr_len} + ONE;
            state <= ST_DROP;
          end else begin
            dest  <= hdr_addr;
            count <= {1'b0, hdr_len};
            acc   <= bus.data;
            state <= (hdr_len == '0) ? ST_PARITY : ST_PAYLOAD;
          end
        end
        // a flushed destination turns the rest of the packet (incl. parity) into a drop
        ST_PAYLOAD: if (flush_x[dest]) begin
          count <= accept ? count : count + ONE;
          state <= ST_DROP;
        end else if (accept) begin
          acc   <= acc ^ bus.data;
          count <= count - ONE;
          if (count == ONE) state <= ST_PARITY;
        end
        ST_PARITY: if (flush_x[dest]) begin
          count <= ONE;
          state <= accept ? ST_IDLE : ST_DROP;
        end else if (accept) begin
          err_q <= (acc ^ bus.data) != '0;
          state <= ST_IDLE;
        end
        default: if (accept) begin
          count <= count - ONE;
          if (count == ONE) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.suspend_data = suspend;
  assign bus.err          = err_q;
  assign bus.drop         = drop_q;
  assign bus.vld_out      = ~empty;
  assign bus.data_out     = rd_data;
  assign bus.timeout      = tpulse;
endmodule
